// File: rtl/uart_pkg.sv
// uart_pkg: shared byte width and launch FSM encoding for the UART blocks
package uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock byte FIFO with registered occupancy and sticky overflow
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic              ovf_clr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wp_q, rp_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d, wr_acc, rd_acc;
  assign full_o     = count_q == (ADDR_W+1)'(DEPTH);
  assign empty_o    = count_q == '0;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign rd_data_o  = mem_q[rp_q];
  assign wr_acc     = wr_en_i & ~full_o;
  assign rd_acc     = rd_en_i & ~empty_o;
  // a dropped write sets the flag even when a clear arrives in the same cycle
  assign ovf_d      = (wr_en_i & full_o) | (ovf_q & ~ovf_clr_i);
  assign count_d    = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_q + ADDR_W'(wr_acc);
      rp_q    <= rp_q + ADDR_W'(rd_acc);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wp_q] <= wr_data_i;
  end
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: buffers CPU bytes and launches them one at a time into the UART transmitter
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data
);
  tx_state_e         state_q, state_d;
  logic              pop, tx_start_q;
  logic [DATA_W-1:0] rd_data, tx_data_q;
  uart_sync_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .rd_en_i    (pop),
    .ovf_clr_i  (ovf_clr),
    .rd_data_o  (rd_data),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .overflow_o (overflow)
  );
  // checking busy in IDLE keeps a post-reset queue from starting into a frame still on the wire
  always_comb begin
    pop     = state_q == IDLE && !empty && !tx_busy;
    state_d = pop                               ? ISSUE     :
              state_q == ISSUE                  ? WAIT_ACK  :
              (state_q == WAIT_ACK && tx_busy)  ? WAIT_DONE :
              (state_q == WAIT_DONE && !tx_busy) ? IDLE     : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= pop;
      if (pop) tx_data_q <= rd_data;
    end
  end
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed vectors plus transmitter model for the UART transmit queue
module tb_uart_tx_queue;
  import uart_pkg::*;
  localparam int AW = 4;
  localparam int DW = 8;
  typedef struct {
    logic        we;
    logic [7:0]  d;
    logic        clr;
    logic [AW:0] cnt;
    logic        full;
    logic        empty;
    logic        ovf;
  } vec_t;
  logic          clk = 1'b0;
  logic          rst = 1'b1, wr_en = 1'b0, ovf_clr = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          tx_busy, tx_start, full, empty, overflow;
  logic [DW-1:0] tx_data;
  logic [AW:0]   count;
  logic          hold_busy = 1'b0;
  int            busy_len = 4, busy_cnt = 0, idle_cnt = 100;
  int            n_chk = 0, n_fail = 0;
  logic [7:0]    sent [$];
  vec_t          tv [21];
  always #5 clk = ~clk;
  assign tx_busy = hold_busy | (busy_cnt != 0);
  uart_tx_queue #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask
  task automatic wait_sent(input int n, input int budget);
    int c = 0;
    while (sent.size() < n && c < budget) begin
      step();
      c++;
    end
    chk("sent_timeout", sent.size() >= n, 1);
  endtask
  // transmitter model: never resets, busy for busy_len cycles after each start
  always @(negedge clk) begin
    idle_cnt = tx_busy ? 0 : idle_cnt + 1;
    if (tx_start) begin
      sent.push_back(tx_data);
      chk("start_while_busy", tx_busy, 0);
      chk("start_gap", idle_cnt >= 2, 1);
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) busy_cnt--;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 17; i++)
      tv[i] = '{1'b1, 8'(i), 1'b0, 5'(i < 16 ? i + 1 : 16), i >= 15, 1'b0, i == 16};
    tv[17] = '{1'b1, 8'hAA, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1};
    tv[18] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0};
    tv[19] = '{1'b1, 8'hBB, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};
    tv[20] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0};
    wr_en = 1'b1;
    wr_data = 8'h99;
    step(3);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    rst = 1'b0;
    wr_en = 1'b0;
    step();
    chk("rst_write_ignored", count, 0);
    chk("rst_write_no_start", tx_start, 0);
    // single byte latency
    step(5);
    sent.delete();
    wr(8'h55);
    chk("single_count1", count, 1);
    chk("single_empty0", empty, 0);
    chk("single_nostart", tx_start, 0);
    step();
    chk("single_start", tx_start, 1);
    chk("single_data", tx_data, 8'h55);
    chk("single_count0", count, 0);
    chk("single_empty1", empty, 1);
    step();
    chk("single_start_1cyc", tx_start, 0);
    chk("single_data_held", tx_data, 8'h55);
    step(10);
    chk("single_pulses", sent.size(), 1);
    // burst against a slow transmitter
    busy_len = 100;
    sent.delete();
    for (int b = 1; b <= 5; b++) wr(8'(b));
    wait_sent(5, 1000);
    step(120);
    chk("burst_pulses", sent.size(), 5);
    for (int i = 0; i < 5 && i < sent.size(); i++) chk("burst_order", sent[i], i + 1);
    // fill, overflow and clear, table-driven with the transmitter held busy
    busy_len = 3;
    hold_busy = 1'b1;
    sent.delete();
    for (int i = 0; i < 21; i++) begin
      wr_en = tv[i].we;
      wr_data = tv[i].d;
      ovf_clr = tv[i].clr;
      step();
      chk($sformatf("tv%0d_count", i), count, tv[i].cnt);
      chk($sformatf("tv%0d_full", i), full, tv[i].full);
      chk($sformatf("tv%0d_empty", i), empty, tv[i].empty);
      chk($sformatf("tv%0d_ovf", i), overflow, tv[i].ovf);
      chk($sformatf("tv%0d_start", i), tx_start, 0);
    end
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    // write into a full queue on the same cycle as a pop is still dropped
    hold_busy = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    chk("droppop_count", count, 15);
    chk("droppop_ovf", overflow, 1);
    chk("droppop_start", tx_start, 1);
    chk("droppop_data", tx_data, 8'h00);
    wait_sent(16, 2000);
    step(20);
    chk("full_pulses", sent.size(), 16);
    for (int i = 0; i < 16 && i < sent.size(); i++) chk("full_order", sent[i], i);
    chk("full_drained", empty, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    // pointer wrap-around over three rounds
    busy_len = 2;
    for (int r = 0; r < 3; r++) begin
      sent.delete();
      for (int i = 0; i < 12; i++) wr(8'(8'h40 + r * 12 + i));
      wait_sent(12, 500);
      step(10);
      chk("wrap_pulses", sent.size(), 12);
      for (int i = 0; i < 12 && i < sent.size(); i++) chk("wrap_order", sent[i], 8'h40 + r * 12 + i);
      chk("wrap_empty", empty, 1);
      chk("wrap_count", count, 0);
    end
    // simultaneous write and pop at count 3
    sent.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 3; i++) wr(8'(8'h71 + i));
    chk("sim_count3", count, 3);
    hold_busy = 1'b0;
    wr(8'h74);
    chk("sim_count_held", count, 3);
    chk("sim_start", tx_start, 1);
    chk("sim_data", tx_data, 8'h71);
    wait_sent(4, 500);
    step(10);
    chk("sim_pulses", sent.size(), 4);
    for (int i = 0; i < 4 && i < sent.size(); i++) chk("sim_order", sent[i], 8'h71 + i);
    // reset while a frame is on the wire with four bytes queued
    busy_len = 40;
    sent.delete();
    wr(8'h80);
    for (int i = 1; i <= 4; i++) wr(8'(8'h80 + i));
    chk("midrst_count4", count, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_start", tx_start, 0);
    step(60);
    chk("midrst_no_start", sent.size(), 1);
    wr(8'h3C);
    wait_sent(2, 100);
    step(10);
    chk("midrst_pulses", sent.size(), 2);
    if (sent.size() >= 2) chk("midrst_data", sent[1], 8'h3C);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
